iot_collect: RTL and testbench

Front-end collector of the IoT data-filtering datapath. It assembles the serial byte stream into 128-bit words and generates the word and round counters that every filter stage consumes, including the peak-minimum stage. A round is 8 words of 16 bytes. Between rounds it asserts a busy gap so the host pauses while the filter stages emit their per-round result.

---
 rtl/iot_collect.sv | 135 +++++++++++++
 tb/tb_iot_collect.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iot_collect.sv
// Front-end collector: packs the serial byte stream into 128-bit words, tracks byte/word
// indices within a round and holds busy for a fixed gap between rounds.
module iot_collect #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned NUM_ROUNDS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_en,
  input  logic [7:0]   iot_in,
  output logic         busy,
  output logic [127:0] data,
  output logic [3:0]   cnt_cycle,
  output logic [2:0]   cnt_data,
  output logic         word_valid,
  output logic         done,
  output logic         drop_err
);

  localparam int unsigned       RoundW      = $clog2(NUM_ROUNDS + 1);
  localparam logic [RoundW-1:0] RoundsTotal = RoundW'(NUM_ROUNDS);
  localparam logic [3:0]        GapLoad     = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StCollect, StGap, StDone} state_e;

  state_e              state_q, state_d;
  logic [127:0]        data_q, data_d;
  logic [3:0]          cyc_q, cyc_d;
  logic [2:0]          dat_q, dat_d;
  logic [3:0]          gap_q, gap_d;
  logic [RoundW-1:0]   round_q, round_d;
  logic                fresh_q, fresh_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic                wv_q, wv_d;
  logic                accept;

  assign accept = in_en & ~busy_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cyc_d   = cyc_q;
    dat_d   = dat_q;
    gap_d   = gap_q;
    round_d = round_q;
    fresh_d = fresh_q;
    wv_d    = 1'b0;
    drop_d  = drop_q | (in_en & busy_q);

    case (state_q)
      StCollect: begin
        if (accept) begin
          data_d = {data_q[119:0], iot_in};
          // First byte after reset or a gap restarts indexing at word 0, byte 0.
          if (fresh_q) begin
            cyc_d   = 4'd0;
            dat_d   = 3'd0;
            fresh_d = 1'b0;
          end else begin
            cyc_d = cyc_q + 4'd1;
            if (cyc_q == 4'd15) begin
              dat_d = dat_q + 3'd1;
            end
          end
          if (cyc_d == 4'd15) begin
            wv_d = 1'b1;
            if (dat_d == 3'd7) begin
              round_d = round_q + 1'b1;
              gap_d   = GapLoad;
              state_d = StGap;
            end
          end
        end
      end
      StGap: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (round_q == RoundsTotal) begin
          state_d = StDone;
        end else begin
          state_d = StCollect;
          fresh_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StCollect;
      end
    endcase

    busy_d = (state_d != StCollect);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StCollect;
      data_q  <= '0;
      cyc_q   <= '0;
      dat_q   <= '0;
      gap_q   <= '0;
      round_q <= '0;
      fresh_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cyc_q   <= cyc_d;
      dat_q   <= dat_d;
      gap_q   <= gap_d;
      round_q <= round_d;
      fresh_q <= fresh_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      wv_q    <= wv_d;
    end
  end

  assign busy       = busy_q;
  assign data       = data_q;
  assign cnt_cycle  = cyc_q;
  assign cnt_data   = dat_q;
  assign word_valid = wv_q;
  assign done       = done_q;
  assign drop_err   = drop_q;

endmodule

// File: tb/tb_iot_collect.sv
// Bench for iot_collect: a cycle model pushes expected words to a queue that a negedge
// monitor pops on word_valid; feature tasks add their own inline checks.
module tb_iot_collect;

  localparam int unsigned GapCycles = 3;
  localparam int unsigned NumRounds = 2;

  logic         clk;
  logic         rst;
  logic         in_en;
  logic [7:0]   iot_in;
  logic         busy;
  logic [127:0] data;
  logic [3:0]   cnt_cycle;
  logic [2:0]   cnt_data;
  logic         word_valid;
  logic         done;
  logic         drop_err;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] mon_word;
  bit           mon_en = 1'b0;

  // Reference model state
  logic [127:0] m_data;
  logic [3:0]   m_cyc;
  logic [2:0]   m_dat;
  int           m_state;
  int           m_gap;
  int           m_round;
  logic         m_fresh, m_busy, m_done, m_drop, m_wv;

  iot_collect #(
    .GAP_CYCLES(GapCycles),
    .NUM_ROUNDS(NumRounds)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .iot_in    (iot_in),
    .busy      (busy),
    .data      (data),
    .cnt_cycle (cnt_cycle),
    .cnt_data  (cnt_data),
    .word_valid(word_valid),
    .done      (done),
    .drop_err  (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_data = '0; m_cyc = '0; m_dat = '0;
    m_state = 0; m_gap = 0; m_round = 0;
    m_fresh = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_drop = 1'b0; m_wv = 1'b0;
    exp_q.delete();
  endtask

  // Advances the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic acc;
    acc  = in_en && !m_busy;
    m_wv = 1'b0;
    if (in_en && m_busy) m_drop = 1'b1;
    if (m_state == 1) begin
      if (m_gap != 0) m_gap = m_gap - 1;
      else if (m_round == NumRounds) begin
        m_state = 2;
        m_done  = 1'b1;
      end else begin
        m_state = 0;
        m_busy  = 1'b0;
        m_fresh = 1'b1;
      end
    end else if (m_state == 0 && acc) begin
      m_data = {m_data[119:0], iot_in};
      if (m_fresh) begin
        m_cyc = 4'd0; m_dat = 3'd0; m_fresh = 1'b0;
      end else begin
        if (m_cyc == 4'd15) m_dat = m_dat + 3'd1;
        m_cyc = m_cyc + 4'd1;
      end
      if (m_cyc == 4'd15) begin
        m_wv = 1'b1;
        exp_q.push_back(m_data);
        if (m_dat == 3'd7) begin
          m_round = m_round + 1;
          m_state = 1;
          m_busy  = 1'b1;
          m_gap   = GapCycles - 1;
        end
      end
    end
  endtask

  task automatic cycle(input logic en, input logic [7:0] b);
    in_en  = en;
    iot_in = b;
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ({busy, done, drop_err, word_valid} !== {m_busy, m_done, m_drop, m_wv}) begin
        errors++;
        $display("FAIL mon_flags t=%0t busy/done/drop/wv got %b%b%b%b exp %b%b%b%b", $time,
                 busy, done, drop_err, word_valid, m_busy, m_done, m_drop, m_wv);
      end
      checks++;
      if (cnt_cycle !== m_cyc || cnt_data !== m_dat) begin
        errors++;
        $display("FAIL mon_counters t=%0t got %0d/%0d exp %0d/%0d", $time,
                 cnt_data, cnt_cycle, m_dat, m_cyc);
      end
      if (word_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_word t=%0t got %h exp none", $time, data);
        end else begin
          mon_word = exp_q.pop_front();
          if (data !== mon_word) begin
            errors++;
            $display("FAIL sb_word t=%0t got %h exp %h", $time, data, mon_word);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; in_en = 1'b0; iot_in = 8'h00;
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (data !== 128'h0) begin errors++; $display("FAIL rst_data got %h exp 0", data); end
    checks++;
    if ({cnt_cycle, cnt_data} !== 7'h0) begin
      errors++; $display("FAIL rst_counters got %h exp 0", {cnt_cycle, cnt_data});
    end
    checks++;
    if ({busy, done, drop_err, word_valid} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags got %b exp 0000", {busy, done, drop_err, word_valid});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    cycle(1'b0, 8'h00);
  endtask

  task automatic test_word();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i));
    checks++;
    if (data !== 128'h000102030405060708090A0B0C0D0E0F) begin
      errors++; $display("FAIL word0_data got %h exp 000102..0F", data);
    end
    checks++;
    if (cnt_cycle !== 4'd15 || cnt_data !== 3'd0) begin
      errors++; $display("FAIL word0_idx got %0d/%0d exp 0/15", cnt_data, cnt_cycle);
    end
    checks++;
    if (word_valid !== 1'b1) begin errors++; $display("FAIL word0_valid got %b exp 1", word_valid); end
    cycle(1'b0, 8'h00);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL word0_valid_pulse got %b exp 0", word_valid);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(8'h10 + i));
      if (i == 5) begin
        for (int s = 0; s < 3; s++) begin
          cycle(1'b0, 8'hEE);
          checks++;
          if (cnt_cycle !== 4'd5 || cnt_data !== 3'd1 || data[7:0] !== 8'h15 || word_valid !== 1'b0)
          begin
            errors++;
            $display("FAIL stall_hold got %0d/%0d byte %h wv %b exp 1/5 byte 15 wv 0",
                     cnt_data, cnt_cycle, data[7:0], word_valid);
          end
        end
      end
    end
    checks++;
    if (data !== 128'h101112131415161718191A1B1C1D1E1F || word_valid !== 1'b1) begin
      errors++; $display("FAIL stall_word got %h wv %b exp 1011..1F wv 1", data, word_valid);
    end
  endtask

  task automatic test_round_gap();
    for (int i = 0; i < 96; i++) cycle(1'b1, 8'(8'h20 + i));
    checks++;
    if (busy !== 1'b1 || word_valid !== 1'b1 || cnt_data !== 3'd7 || cnt_cycle !== 4'd15) begin
      errors++;
      $display("FAIL round_end got busy %b wv %b idx %0d/%0d exp 1 1 7/15",
               busy, word_valid, cnt_data, cnt_cycle);
    end
    checks++;
    if (drop_err !== 1'b0) begin errors++; $display("FAIL round_drop_early got %b exp 0", drop_err); end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 8'hDD);
      checks++;
      if (busy !== (k < 2) || drop_err !== 1'b1 || data[7:0] !== 8'h7F) begin
        errors++;
        $display("FAIL gap_%0d got busy %b drop %b byte %h exp busy %b drop 1 byte 7f",
                 k, busy, drop_err, data[7:0], (k < 2));
      end
    end
    cycle(1'b1, 8'hA0);
    checks++;
    if (cnt_cycle !== 4'd0 || cnt_data !== 3'd0 || data[7:0] !== 8'hA0 || drop_err !== 1'b1) begin
      errors++;
      $display("FAIL after_gap got %0d/%0d byte %h drop %b exp 0/0 byte a0 drop 1",
               cnt_data, cnt_cycle, data[7:0], drop_err);
    end
  endtask

  task automatic test_done();
    for (int i = 0; i < 127; i++) cycle(1'b1, 8'(i + 1));
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 8'hCC);
      checks++;
      if (busy !== 1'b1 || (k >= 2 && done !== 1'b1) || cnt_cycle !== 4'd15 || cnt_data !== 3'd7 ||
          data !== m_data) begin
        errors++;
        $display("FAIL done_%0d got busy %b done %b idx %0d/%0d data %h exp 1 1 7/15 %h",
                 k, busy, done, cnt_data, cnt_cycle, data, m_data);
      end
    end
  endtask

  task automatic test_async_reset();
    in_en = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || drop_err !== 1'b0) begin
      errors++; $display("FAIL leave_done got %b%b%b exp 000", done, busy, drop_err);
    end
    for (int i = 0; i < 58; i++) cycle(1'b1, 8'(i));
    checks++;
    if (cnt_data !== 3'd3 || cnt_cycle !== 4'd9) begin
      errors++; $display("FAIL pre_rst_idx got %0d/%0d exp 3/9", cnt_data, cnt_cycle);
    end
    in_en = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (data !== 128'h0 || {cnt_cycle, cnt_data} !== 7'h0 ||
        {busy, done, drop_err, word_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL async_rst got data %h idx %h flags %b exp all 0", data,
               {cnt_cycle, cnt_data}, {busy, done, drop_err, word_valid});
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'hF0 + i));
    checks++;
    if (data !== 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF || cnt_data !== 3'd0 ||
        cnt_cycle !== 4'd15 || word_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_word got %h %0d/%0d wv %b exp f0..ff 0/15 1",
               data, cnt_data, cnt_cycle, word_valid);
    end
  endtask

  task automatic test_drain();
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL sb_missing_words got %0d pending exp 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_stall();
    test_round_gap();
    test_done();
    test_async_reset();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
